pipe_stage_buf: RTL and testbench

Parametrised pipeline stage register that replaces the fixed per-stage latch interfaces (such as the memory/writeback latch) with one generic, elastic stage. It carries an arbitrary-width payload between two pipeline stages with a valid/ready handshake and an optional two-entry skid buffer. It also provides a global enable for cache-hit gating, a synchronous flush, and sticky halt capture. One instance sits between each pair of stages (IF/ID, ID/EX, EX/M, M/WB); the hazard unit drives `flush` and `en`.

---
 rtl/pipe_stage_buf.sv | 127 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic elastic pipeline stage register with valid/ready
// handshake, optional two-entry skid buffer, enable gating, flush and halt.
//
// Ports:
//   CLK, RST           rising-edge clock, async active-high reset
//   en, flush          stage enable (hit gating), synchronous squash
//   in_valid/in_ready  upstream handshake, in_data/in_halt payload
//   out_valid/out_ready downstream handshake, out_data/out_halt head payload
//   halted             sticky, set once a HALT beat is delivered
//   occ                number of entries held (0..2)
module pipe_stage_buf #(
   parameter int DW   = 32,
   parameter bit SKID = 1'b1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          en,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_halt,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_halt,
   output logic          halted,
   output logic [1:0]    occ
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e          state_q;
   logic [DW-1:0]   head_q;
   logic [DW-1:0]   skid_q;
   logic            head_h_q;
   logic            skid_h_q;
   logic            halted_q;
   logic            acc;
   logic            dlv;

   assign out_valid = (state_q != EMPTY);
   // Vacated entries are zeroed, so the head reads 0 whenever empty.
   assign out_data  = head_q;
   assign out_halt  = head_h_q;
   assign halted    = halted_q;
   assign occ       = state_q;

   generate
      if (SKID) begin : g_skid
         // Registered ready: a one-cycle stall lands in the skid entry.
         assign in_ready = !halted_q && (state_q != TWO);
      end else begin : g_reg
         // Single entry: can take a beat only if the head leaves now.
         assign in_ready = !halted_q &&
                           ((state_q == EMPTY) || (out_ready && en));
      end
   endgenerate

   assign acc = en && in_valid && in_ready;
   assign dlv = en && out_valid && out_ready;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= EMPTY;
         head_q   <= '0;
         skid_q   <= '0;
         head_h_q <= 1'b0;
         skid_h_q <= 1'b0;
         halted_q <= 1'b0;
      end else if (en) begin
         // A deliver in a flush cycle still counts, so halt capture
         // happens regardless of flush.
         if (dlv && head_h_q) begin
            halted_q <= 1'b1;
         end
         if (flush) begin
            state_q  <= EMPTY;
            head_q   <= '0;
            skid_q   <= '0;
            head_h_q <= 1'b0;
            skid_h_q <= 1'b0;
         end else begin
            unique case (state_q)
               EMPTY: begin
                  if (acc) begin
                     head_q   <= in_data;
                     head_h_q <= in_halt;
                     state_q  <= ONE;
                  end
               end
               ONE: begin
                  if (acc && dlv) begin
                     head_q   <= in_data;
                     head_h_q <= in_halt;
                  end else if (acc) begin
                     skid_q   <= in_data;
                     skid_h_q <= in_halt;
                     state_q  <= TWO;
                  end else if (dlv) begin
                     head_q   <= '0;
                     head_h_q <= 1'b0;
                     state_q  <= EMPTY;
                  end
               end
               TWO: begin
                  if (dlv) begin
                     head_q   <= skid_q;
                     head_h_q <= skid_h_q;
                     skid_q   <= '0;
                     skid_h_q <= 1'b0;
                     state_q  <= ONE;
                  end
               end
               default: begin
                  state_q <= EMPTY;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed self-checking bench for pipe_stage_buf,
// one SKID=1 instance and one SKID=0 instance.
module tb_pipe_stage_buf;

   logic        CLK;
   logic        RST;

   logic        en, flush, iv, ih, ordy;
   logic [31:0] id;
   logic        ir, ov, oh, hl;
   logic [31:0] od;
   logic [1:0]  oc;

   logic        b_en, b_flush, b_iv, b_ih, b_ordy;
   logic [31:0] b_id;
   logic        b_ir, b_ov, b_oh, b_hl;
   logic [31:0] b_od;
   logic [1:0]  b_oc;

   int checks = 0;
   int errors = 0;

   pipe_stage_buf #(.DW(32), .SKID(1'b1)) u_skid (
      .CLK(CLK), .RST(RST), .en(en), .flush(flush),
      .in_valid(iv), .in_ready(ir), .in_data(id), .in_halt(ih),
      .out_valid(ov), .out_ready(ordy), .out_data(od), .out_halt(oh),
      .halted(hl), .occ(oc)
   );

   pipe_stage_buf #(.DW(32), .SKID(1'b0)) u_reg (
      .CLK(CLK), .RST(RST), .en(b_en), .flush(b_flush),
      .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_halt(b_ih),
      .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od),
      .out_halt(b_oh), .halted(b_hl), .occ(b_oc)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   initial begin
      RST = 1'b0;
      en = 1'b1; flush = 1'b0; iv = 1'b0; ih = 1'b0; ordy = 1'b0;
      id = '0;
      b_en = 1'b1; b_flush = 1'b0; b_iv = 1'b0; b_ih = 1'b0;
      b_ordy = 1'b0; b_id = '0;
      #1 RST = 1'b1;
      #1;
      chk("rst_occ", 32'(oc), 0);
      chk("rst_ov", 32'(ov), 0);
      chk("rst_od", od, 0);
      chk("rst_oh", 32'(oh), 0);
      chk("rst_hl", 32'(hl), 0);
      chk("rst_ir", 32'(ir), 1);
      chk("rst_b_ir", 32'(b_ir), 1);
      chk("rst_b_occ", 32'(b_oc), 0);
      tick();
      tick();
      RST = 1'b0;

      // streaming at full rate
      iv = 1'b1; id = 32'h1; ordy = 1'b1;
      #1 chk("str_ir", 32'(ir), 1);
      tick();
      id = 32'h2;
      #1 chk("str_od1", od, 32'h1);
      chk("str_occ1", 32'(oc), 1);
      chk("str_ov1", 32'(ov), 1);
      tick();
      id = 32'h3;
      #1 chk("str_od2", od, 32'h2);
      chk("str_occ2", 32'(oc), 1);
      tick();
      iv = 1'b0;
      #1 chk("str_od3", od, 32'h3);
      chk("str_occ3", 32'(oc), 1);
      tick();
      #1 chk("str_end_ov", 32'(ov), 0);
      chk("str_end_od", od, 0);
      chk("str_end_occ", 32'(oc), 0);

      // backpressure into the skid entry
      ordy = 1'b0; iv = 1'b1; id = 32'hA;
      tick();
      id = 32'hB;
      #1 chk("bp_ir_absorb", 32'(ir), 1);
      chk("bp_od_a", od, 32'hA);
      tick();
      iv = 1'b0; ordy = 1'b1;
      #1 chk("bp_occ2", 32'(oc), 2);
      chk("bp_ir0", 32'(ir), 0);
      chk("bp_head_a", od, 32'hA);
      tick();
      #1 chk("bp_head_b", od, 32'hB);
      chk("bp_occ1", 32'(oc), 1);
      chk("bp_ir1", 32'(ir), 1);
      tick();
      #1 chk("bp_empty", 32'(oc), 0);

      // flush with both entries full
      ordy = 1'b0; iv = 1'b1; id = 32'h11;
      tick();
      id = 32'h12;
      tick();
      flush = 1'b1; id = 32'hE;
      #1 chk("fl_pre_occ", 32'(oc), 2);
      tick();
      flush = 1'b0; iv = 1'b0; ordy = 1'b1;
      #1 chk("fl_occ", 32'(oc), 0);
      chk("fl_ov", 32'(ov), 0);
      chk("fl_od", od, 0);
      tick();
      #1 chk("fl_no_e_ov", 32'(ov), 0);
      chk("fl_no_e_od", od, 0);

      // flush in ONE drops the beat presented alongside
      iv = 1'b1; id = 32'h21; ordy = 1'b0;
      tick();
      flush = 1'b1; id = 32'h22;
      #1 chk("fl1_ir", 32'(ir), 1);
      tick();
      flush = 1'b0; iv = 1'b0;
      #1 chk("fl1_occ", 32'(oc), 0);
      chk("fl1_ov", 32'(ov), 0);

      // enable low stalls everything
      ordy = 1'b1; iv = 1'b1; id = 32'h31;
      tick();
      en = 1'b0; id = 32'h32;
      for (int i = 0; i < 3; i++) begin
         #1 chk("en0_occ", 32'(oc), 1);
         chk("en0_od", od, 32'h31);
         chk("en0_ov", 32'(ov), 1);
         tick();
      end
      en = 1'b1;
      #1 chk("en0_held_od", od, 32'h31);
      tick();
      id = 32'h33;
      #1 chk("en1_od32", od, 32'h32);
      tick();
      iv = 1'b0;
      #1 chk("en1_od33", od, 32'h33);
      tick();
      #1 chk("en1_empty", 32'(oc), 0);

      // flush ignored while disabled
      iv = 1'b1; id = 32'h41; ordy = 1'b0;
      tick();
      iv = 1'b0; en = 1'b0; flush = 1'b1;
      tick();
      en = 1'b1; flush = 1'b0;
      #1 chk("fl_en0_occ", 32'(oc), 1);
      chk("fl_en0_od", od, 32'h41);
      ordy = 1'b1;
      tick();

      // halt capture and drain
      iv = 1'b1; id = 32'h5; ih = 1'b0; ordy = 1'b1;
      tick();
      id = 32'h6; ih = 1'b1;
      #1 chk("h_od5", od, 32'h5);
      tick();
      ordy = 1'b0; id = 32'h8; ih = 1'b0;
      #1 chk("h_od6", od, 32'h6);
      chk("h_oh6", 32'(oh), 1);
      chk("h_hl_pre", 32'(hl), 0);
      tick();
      iv = 1'b0; ordy = 1'b1;
      #1 chk("h_occ2", 32'(oc), 2);
      tick();
      #1 chk("h_hl_set", 32'(hl), 1);
      chk("h_drain_od8", od, 32'h8);
      chk("h_drain_oh", 32'(oh), 0);
      chk("h_ir0", 32'(ir), 0);
      iv = 1'b1; id = 32'h7;
      tick();
      #1 chk("h_occ0", 32'(oc), 0);
      chk("h_ov0", 32'(ov), 0);
      tick();
      #1 chk("h_no7_ov", 32'(ov), 0);
      chk("h_no7_od", od, 0);
      chk("h_ir_held", 32'(ir), 0);
      iv = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      #1 chk("h_flush_keeps", 32'(hl), 1);
      RST = 1'b1;
      #1 chk("h_rst_clears", 32'(hl), 0);
      chk("h_rst_ir", 32'(ir), 1);
      tick();
      RST = 1'b0;

      // SKID=0: combinational ready
      b_ordy = 1'b0; b_iv = 1'b1; b_id = 32'hC;
      tick();
      b_id = 32'hD;
      #1 chk("s0_ir_stall", 32'(b_ir), 0);
      chk("s0_occ", 32'(b_oc), 1);
      chk("s0_od_c", b_od, 32'hC);
      tick();
      #1 chk("s0_hold_c", b_od, 32'hC);
      b_ordy = 1'b1;
      #1 chk("s0_ir_comb", 32'(b_ir), 1);
      tick();
      b_iv = 1'b0;
      #1 chk("s0_od_d", b_od, 32'hD);
      chk("s0_occ_d", 32'(b_oc), 1);
      tick();
      #1 chk("s0_empty_occ", 32'(b_oc), 0);
      chk("s0_empty_od", b_od, 0);
      b_iv = 1'b1; b_id = 32'hF;
      tick();
      b_iv = 1'b0; b_en = 1'b0;
      #1 chk("s0_en0_ir", 32'(b_ir), 0);
      b_en = 1'b1;
      tick();
      #1 chk("s0_final_occ", 32'(b_oc), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
